// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC-driven memory reads, prefetch FIFO toward decode, redirect flush.
// Optional build macro FETCH_PERF_EN adds the perf_fetched / perf_busy counters.
module fetch_unit #(
  parameter logic [31:0] start_addr = 32'h8002_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic        mem_busy,
  input  logic [31:0] mem_data_out,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn_word,
  output logic [31:0] insn_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_busy
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [31:0]      pc_r;
  logic             inflight_r;
  logic [31:0]      inflight_pc_r;
  logic [31:0]      fifo_word_r [FIFO_DEPTH];
  logic [31:0]      fifo_pc_r   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W:0]   occupancy_s;
  logic             credit_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             unused_s;

  assign unused_s        = ^redirect_pc[1:0];
  assign mem_access_size = 2'b00;
  assign mem_rw          = 1'b0;
  assign mem_address     = pc_r;

  // Queued plus in-flight words must never exceed the buffer, so an issued word always has a slot.
  assign occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
  assign credit_s    = (occupancy_s < DEPTH_C);
  assign mem_enable  = (state_r == S_FETCH) && credit_s && fetch_en && !redirect_valid;
  assign accept_s    = mem_enable && !mem_busy;
  assign insn_valid  = (count_r != {CNT_W{1'b0}});
  assign pop_s       = insn_valid && insn_ready;
  assign push_s      = inflight_r && !redirect_valid;

  // FIFO head presented to decode; zero while empty.
  always_comb begin
    insn_word = 32'h0000_0000;
    insn_pc   = 32'h0000_0000;
    if (insn_valid) begin
      insn_word = fifo_word_r[rd_ptr_r];
      insn_pc   = fifo_pc_r[rd_ptr_r];
    end else begin
      insn_word = 32'h0000_0000;
      insn_pc   = 32'h0000_0000;
    end
  end

  // Next-state logic; a redirect overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect_valid) begin
      state_nxt_s = S_FLUSH;
    end else begin
      case (state_r)
        S_IDLE:  state_nxt_s = fetch_en ? S_FETCH : S_IDLE;
        S_FETCH: begin
          if (!fetch_en)                state_nxt_s = S_IDLE;
          else if (!credit_s && !pop_s) state_nxt_s = S_FULL;
          else                          state_nxt_s = S_FETCH;
        end
        S_FULL: begin
          if (!fetch_en)               state_nxt_s = S_IDLE;
          else if (credit_s || pop_s)  state_nxt_s = S_FETCH;
          else                         state_nxt_s = S_FULL;
        end
        S_FLUSH: state_nxt_s = fetch_en ? S_FETCH : S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Control state: FSM, PC, in-flight tracking, FIFO pointers and count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= S_IDLE;
      pc_r          <= start_addr;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
    end else if (redirect_valid) begin
      // The head handshake of this cycle still completes; everything else is dropped.
      state_r    <= state_nxt_s;
      pc_r       <= {redirect_pc[31:2], 2'b00};
      inflight_r <= 1'b0;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= accept_s;
      if (accept_s) begin
        pc_r          <= pc_r + 32'd4;
        inflight_pc_r <= pc_r;
      end
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      count_r <= count_r + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
    end
  end

  // Buffer storage; contents are don't-care until the count covers them.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      fifo_word_r[wr_ptr_r] <= mem_data_out;
      fifo_pc_r[wr_ptr_r]   <= inflight_pc_r;
    end
  end

`ifdef FETCH_PERF_EN
  // Perf counters survive redirects; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_busy    <= 32'd0;
    end else begin
      if (pop_s)                  perf_fetched <= perf_fetched + 32'd1;
      if (mem_enable && mem_busy) perf_busy    <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed scenarios.
module tb_fetch_unit;
  localparam logic [31:0] START = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset, fetch_en, redirect_valid, mem_busy, insn_ready;
  logic [31:0] redirect_pc, mem_address, mem_data_out, insn_word, insn_pc;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable, insn_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_busy;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: accepted-but-undelivered words as address queues.
  logic [31:0] mq[$];
  logic [31:0] alog[$];
  logic [31:0] dlog[$];
  logic        m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  logic [31:0] m_pc = START;
  logic        m_flush = 1'b0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_address(mem_address), .mem_access_size(mem_access_size), .mem_rw(mem_rw),
    .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_word(insn_word), .insn_pc(insn_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_busy(perf_busy)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Memory: word for the request accepted at an edge is valid during the following cycle.
  always @(posedge clock)
    mem_data_out <= (mem_enable && !mem_busy) ? mem_word(mem_address) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model past the coming edge.
  always @(negedge clock) begin
    check("insn_valid", 32'(insn_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("insn_pc", insn_pc, mq[0]);
      check("insn_word", insn_word, mem_word(mq[0]));
    end
    check("mem_address", mem_address, m_pc);
    check("mem_const", {29'b0, mem_access_size, mem_rw}, 32'h0);
    if (mem_enable) check("credit", 32'((mq.size() + int'(m_infl)) < 4), 32'd1);
    if (redirect_valid || m_flush) check("no_issue_flush", 32'(mem_enable), 32'd0);
    if (reset) begin
      mq.delete();
      m_infl  = 1'b0;
      m_pc    = START;
      m_flush = 1'b0;
    end else begin
      if (mq.size() != 0 && insn_ready) dlog.push_back(mq.pop_front());
      if (redirect_valid) begin
        mq.delete();
        m_infl  = 1'b0;
        m_pc    = {redirect_pc[31:2], 2'b00};
        m_flush = 1'b1;
      end else begin
        m_flush = 1'b0;
        if (m_infl) mq.push_back(m_infl_pc);
        m_infl = mem_enable && !mem_busy;
        if (m_infl) begin
          alog.push_back(m_pc);
          m_infl_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_en = 1'b0; insn_ready = 1'b0;
    redirect_valid = 1'b0; mem_busy = 1'b0; redirect_pc = 32'h0;
    cyc(1);
    reset = 1'b0;
    alog.delete();
    dlog.delete();
  endtask

  task automatic check_seq(input string name, input logic [31:0] base, input int first, input int n);
    check({name, "_len"}, 32'(dlog.size() >= first + n), 32'd1);
    for (int i = 0; i < n && first + i < dlog.size(); i++)
      check(name, dlog[first + i], base + 32'(4 * i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit found;
    reset = 1'b1; fetch_en = 1'b0; insn_ready = 1'b0;
    redirect_valid = 1'b0; mem_busy = 1'b0; redirect_pc = 32'h0;

    // A: reset values, streaming at one word per cycle
    do_reset();
    check("rst_valid", 32'(insn_valid), 32'd0);
    check("rst_enable", 32'(mem_enable), 32'd0);
    check("rst_addr", mem_address, 32'h8002_0000);
    check("rst_word", insn_word, 32'h0);
    check("rst_pc", insn_pc, 32'h0);
    fetch_en = 1'b1; insn_ready = 1'b1;
    lat = 0;
    while (lat < 10 && !insn_valid) begin cyc(1); lat++; end
    // fetch_en sampled at the first edge, head visible two edges later
    check("first_latency", 32'(lat), 32'd3);
    cyc(8);
    check("stream_count", 32'(dlog.size()), 32'd8);
    check("stream_addr0", alog[0], 32'h8002_0000);
    check("stream_addr3", alog[3], 32'h8002_000C);
    check_seq("stream_order", START, 0, 8);

    // B: back-pressure fills exactly four entries, then drains in order
    do_reset();
    fetch_en = 1'b1; insn_ready = 1'b0;
    cyc(8);
    check("full_issued", 32'(alog.size()), 32'd4);
    check("full_enable", 32'(mem_enable), 32'd0);
    check("full_addr", mem_address, 32'h8002_0010);
    check("full_head", insn_pc, 32'h8002_0000);
    insn_ready = 1'b1;
    cyc(10);
    check_seq("drain_order", START, 0, 8);
    check("resume_addr", alog[4], 32'h8002_0010);

    // C: memory busy for three cycles at 0x80020008
    do_reset();
    fetch_en = 1'b1; insn_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (mem_address == 32'h8002_0008) found = 1'b1;
    end
    check("busy_reached", 32'(found), 32'd1);
    mem_busy = 1'b1;
    repeat (3) begin
      check("busy_hold", mem_address, 32'h8002_0008);
      check("busy_req", 32'(mem_enable), 32'd1);
      cyc(1);
    end
    mem_busy = 1'b0;
    check("busy_release", mem_address, 32'h8002_0008);
    cyc(10);
    check_seq("busy_order", START, 0, 8);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'(dlog.size()));
    check("perf_busy", perf_busy, 32'd3);
`endif

    // D: redirect with three queued words and one in flight
    do_reset();
    fetch_en = 1'b1; insn_ready = 1'b0;
    cyc(5);
    check("pre_redir_issued", 32'(alog.size()), 32'd4);
    check("pre_redir_head", insn_pc, 32'h8002_0000);
    redirect_valid = 1'b1; redirect_pc = 32'h8002_0103;
    cyc(1);
    redirect_valid = 1'b0;
    check("redir_valid", 32'(insn_valid), 32'd0);
    check("redir_addr", mem_address, 32'h8002_0100);
    insn_ready = 1'b1;
    cyc(10);
    check("redir_fetch", alog[4], 32'h8002_0100);
    check_seq("redir_order", 32'h8002_0100, 0, 6);

    // E: redirect in the same cycle the first word is popped
    do_reset();
    fetch_en = 1'b1; insn_ready = 1'b1;
    for (int i = 0; i < 10 && !insn_valid; i++) cyc(1);
    check("pop_redir_head", insn_pc, 32'h8002_0000);
    redirect_valid = 1'b1; redirect_pc = 32'h8002_0200;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(8);
    check("pop_redir_kept", dlog[0], 32'h8002_0000);
    check_seq("pop_redir_order", 32'h8002_0200, 1, 4);

    // F: reset while words are queued and in flight
    do_reset();
    fetch_en = 1'b1; insn_ready = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("mid_rst_valid", 32'(insn_valid), 32'd0);
    check("mid_rst_enable", 32'(mem_enable), 32'd0);
    check("mid_rst_addr", mem_address, 32'h8002_0000);
    check("mid_rst_word", insn_word, 32'h0);
    check("mid_rst_pc", insn_pc, 32'h0);
    dlog.delete();
    insn_ready = 1'b1;
    cyc(8);
    check_seq("post_rst_order", START, 0, 4);

    // G: fetch_en drops with a request in flight; that word still arrives
    do_reset();
    fetch_en = 1'b1; insn_ready = 1'b1;
    cyc(3);
    fetch_en = 1'b0;
    cyc(6);
    check("stop_issued", 32'(alog.size()), 32'd2);
    check("stop_delivered", 32'(dlog.size()), 32'd2);
    check("stop_last", dlog[1], 32'h8002_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
